// File: rtl/punit.sv
// punit: binary32 systolic PE, ans = c + a*W with a double-buffered stationary weight.
// Define PUNIT_RNE_EN for round-to-nearest-even; otherwise both ops truncate toward zero.
module punit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic        switch,
  output logic [31:0] ans,
  output logic [31:0] prop,
  output logic [31:0] a_prop
);
`ifdef PUNIT_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0] dormant_q, active_q, a_q, ans_q;
  logic [31:0] ans_d;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  // Zero exponent covers both true zero and subnormals, which are flushed.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic [31:0] ovf(input logic s);
    return RNE ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
  endfunction

  // ext = {mantissa[22:0], guard, round, sticky}; e is the biased exponent as a signed value.
  function automatic logic [31:0] round_pack(input logic s, input logic [9:0] e,
                                             input logic [25:0] ext);
    logic [30:0] mag;
    logic        inc;
    logic [31:0] r;
    inc = RNE & ext[2] & (ext[1] | ext[0] | ext[3]);
    mag = {e[7:0], ext[25:3]} + {30'h0, inc};
    if ($signed(e) <= 0)            r = {s, 31'h0};
    else if ($signed(e) >= 255)     r = ovf(s);
    else if (mag[30:23] == 8'hFF)   r = ovf(s);
    else                            r = {s, mag};
    return r;
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] p;
    logic [9:0]  e;
    logic [31:0] r;
    s = x[31] ^ y[31];
    p = '0;
    e = '0;
    if (is_nan(x) || is_nan(y) || (is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x)))
      r = QNAN;
    else if (is_inf(x) || is_inf(y))
      r = {s, 8'hFF, 23'h0};
    else if (is_zero(x) || is_zero(y))
      r = {s, 31'h0};
    else begin
      p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
      e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127 + {9'd0, p[47]};
      if (p[47]) r = round_pack(s, e, {p[46:22], |p[21:0]});
      else       r = round_pack(s, e, {p[45:21], |p[20:0]});
    end
    return r;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big, sml, r;
    logic [7:0]  d;
    logic [26:0] mb, ms;
    logic [27:0] s;
    logic [25:0] m;
    logic [9:0]  e;
    logic [4:0]  lz;
    big = x; sml = y; d = '0; mb = '0; ms = '0; s = '0; m = '0; e = '0; lz = '0;
    if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && (x[31] != y[31])))
      r = QNAN;
    else if (is_inf(x))                r = x;
    else if (is_inf(y))                r = y;
    else if (is_zero(x) && is_zero(y)) r = {x[31] & y[31], 31'h0};
    else if (is_zero(x))               r = y;
    else if (is_zero(y))               r = x;
    else begin
      if (x[30:0] < y[30:0]) begin big = y; sml = x; end
      d  = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 3'b0};
      ms = {1'b1, sml[22:0], 3'b0};
      // Bits shifted out of the smaller operand collapse into the sticky bit.
      if (d > 8'd26) ms = 27'd1;
      else           ms = (ms >> d) | {26'h0, |(ms & ((27'd1 << d) - 27'd1))};
      s = (big[31] ^ sml[31]) ? {1'b0, mb} - {1'b0, ms} : {1'b0, mb} + {1'b0, ms};
      if (s == 28'h0) r = 32'h0;
      else if (s[27]) begin
        m = {s[26:2], s[1] | s[0]};
        e = {2'b0, big[30:23]} + 10'd1;
        r = round_pack(big[31], e, m);
      end else begin
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        m = s[25:0] << lz;
        e = {2'b0, big[30:23]} - {5'b0, lz};
        r = round_pack(big[31], e, m);
      end
    end
    return r;
  endfunction

  assign ans_d = fadd(fmul(a, active_q), c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dormant_q <= 32'h0;
      active_q  <= 32'h0;
      a_q       <= 32'h0;
      ans_q     <= 32'h0;
    end else begin
      dormant_q <= b;
      a_q       <= a;
      ans_q     <= ans_d;
      if (switch) active_q <= dormant_q;
    end
  end

  assign ans    = ans_q;
  assign prop   = dormant_q;
  assign a_prop = a_q;
endmodule

// File: tb/tb_punit.sv
// Self-checking bench for punit: expected ans values queued at drive time, checked after the edge.
module tb_punit;
  logic        clk, rst, sw;
  logic [31:0] a, b, c, ans, prop, a_prop;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef PUNIT_RNE_EN
  localparam logic [31:0] OVF_POS = 32'h7F80_0000;
  localparam logic [31:0] OVF_NEG = 32'hFF80_0000;
`else
  localparam logic [31:0] OVF_POS = 32'h7F7F_FFFF;
  localparam logic [31:0] OVF_NEG = 32'hFF7F_FFFF;
`endif
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F10  = 32'h4120_0000;

  punit dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .switch(sw),
             .ans(ans), .prop(prop), .a_prop(a_prop));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact binary32 encoding of a small integer (|v| < 2^24).
  function automatic logic [31:0] i2f(input int v);
    logic [31:0] mag, sh;
    int p;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    sh = mag << (23 - p);
    return {(v < 0), 8'(127 + p), sh[22:0]};
  endfunction

  task automatic cycle(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] cv, input logic swv);
    a = av; b = bv; c = cv; sw = swv;
    @(posedge clk); #1;
  endtask

  task automatic load_weight(input logic [31:0] w);
    cycle(32'h0, w, 32'h0, 1'b0);
    cycle(32'h0, w, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; a = '0; b = '0; c = '0; sw = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(F1);
    cycle(F2, F10, F1, 1'b0);
    exp_v = exp_q.pop_front(); n_checks++;
    if (ans !== exp_v) begin n_fail++; $display("FAIL pre_reset_ans got %h want %h", ans, exp_v); end
    else $display("ok pre_reset_ans %h", ans);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ans !== 32'h0) begin n_fail++; $display("FAIL async_reset_ans got %h want 00000000", ans); end
    else $display("ok async_reset_ans %h", ans);
    n_checks++;
    if (prop !== 32'h0) begin n_fail++; $display("FAIL async_reset_prop got %h want 00000000", prop); end
    else $display("ok async_reset_prop %h", prop);
    n_checks++;
    if (a_prop !== 32'h0) begin n_fail++; $display("FAIL async_reset_a_prop got %h want 00000000", a_prop); end
    else $display("ok async_reset_a_prop %h", a_prop);
    #1 rst = 1'b0;
  endtask

  task automatic test_weight_load();
    cycle(32'h0, F10, 32'h0, 1'b0);
    n_checks++;
    if (prop !== F10) begin n_fail++; $display("FAIL load_prop got %h want %h", prop, F10); end
    else $display("ok load_prop %h", prop);
    cycle(32'h0, 32'h0, 32'h0, 1'b1);
    exp_q.push_back(32'h41A8_0000);
    cycle(F2, 32'h0, F1, 1'b0);
    exp_v = exp_q.pop_front(); n_checks++;
    if (ans !== exp_v) begin n_fail++; $display("FAIL load_mac_ans got %h want %h", ans, exp_v); end
    else $display("ok load_mac_ans %h", ans);
    n_checks++;
    if (a_prop !== F2) begin n_fail++; $display("FAIL load_a_prop got %h want %h", a_prop, F2); end
    else $display("ok load_a_prop %h", a_prop);
  endtask

  task automatic test_double_buffer();
    logic [31:0] sw_v[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_t[4] = '{32'h0, F10, F10, F3};
    load_weight(F10);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_t[i]);
      cycle((i == 0) ? 32'h0 : F1, F3, 32'h0, sw_v[i][0]);
      exp_v = exp_q.pop_front(); n_checks++;
      if (ans !== exp_v) begin n_fail++; $display("FAIL dbuf_ans[%0d] got %h want %h", i, ans, exp_v); end
      else $display("ok dbuf_ans[%0d] %h", i, ans);
    end
  endtask

  task automatic run_table(input string name, input logic [31:0] w, input int n,
                           input logic [31:0] av[8], input logic [31:0] cv[8],
                           input logic [31:0] ev[8]);
    load_weight(w);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ev[i]);
      cycle(av[i], w, cv[i], 1'b0);
      exp_v = exp_q.pop_front(); n_checks++;
      if (ans !== exp_v) begin
        n_fail++; $display("FAIL %s[%0d] ans got %h want %h", name, i, ans, exp_v);
      end else $display("ok %s[%0d] ans %h", name, i, ans);
    end
  endtask

  task automatic test_specials();
    logic [31:0] av[8] = '{32'h0, 32'h7F81_2345, F1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] cv[8] = '{32'h0, 32'h0, 32'hFF80_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ev[8] = '{QNAN, QNAN, QNAN, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv[8] = '{F1, 32'h0, 32'h7F80_0000, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] dv[8] = '{F2, 32'h8000_0000, F2, 32'h8000_0001, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] fv[8] = '{32'h0, 32'h8000_0000, 32'hFF80_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0};
    run_table("inf_w", 32'h7F80_0000, 3, av, cv, ev);
    run_table("neg2_w", 32'hC000_0000, 4, bv, dv, fv);
  endtask

  task automatic test_rounding();
    logic [31:0] av[8] = '{32'h3F80_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] cv[8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ev[8] = '{32'h3F80_0002, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv[8] = '{F2, 32'hC000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] fv[8] = '{OVF_POS, OVF_NEG, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_table("round", 32'h3F80_0001, 1, av, cv, ev);
    run_table("overflow", 32'h7F7F_FFFF, 2, bv, cv, fv);
  endtask

  task automatic test_back_to_back();
    int w = 3;
    load_weight(i2f(w));
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i2f(w * (i - 4) + (5 * i - 7)));
      a = i2f(i - 4); b = i2f(w); c = i2f(5 * i - 7); sw = 1'b0;
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); n_checks++;
      if (ans !== exp_v) begin n_fail++; $display("FAIL b2b[%0d] ans got %h want %h", i, ans, exp_v); end
      else $display("ok b2b[%0d] ans %h", i, ans);
    end
  endtask

  task automatic test_switch_held();
    int dorm = 7, act = 7;
    load_weight(i2f(7));
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(i2f(act + 100));
      cycle(F1, i2f(k), i2f(100), 1'b1);
      act = dorm; dorm = k;
      exp_v = exp_q.pop_front(); n_checks++;
      if (ans !== exp_v) begin n_fail++; $display("FAIL held[%0d] ans got %h want %h", k, ans, exp_v); end
      else $display("ok held[%0d] ans %h", k, ans);
    end
  endtask

  task automatic test_reset_midstream();
    load_weight(F10);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (prop !== 32'h0) begin n_fail++; $display("FAIL mid_reset_prop got %h want 00000000", prop); end
    else $display("ok mid_reset_prop %h", prop);
    rst = 1'b0;
    exp_q.push_back(F1);
    cycle(F2, 32'h0, F1, 1'b0);
    exp_v = exp_q.pop_front(); n_checks++;
    if (ans !== exp_v) begin n_fail++; $display("FAIL mid_reset_ans got %h want %h", ans, exp_v); end
    else $display("ok mid_reset_ans %h", ans);
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_double_buffer();
    test_specials();
    test_rounding();
    test_back_to_back();
    test_switch_held();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
